// File: rtl/cntr3_step_ctrl_pkg.sv
// rtl/cntr3_step_ctrl_pkg.sv - shared encodings and helpers for the cntr3 step controller
package cntr3_pkg;

  localparam logic [1:0] S0    = 2'b00;
  localparam logic [1:0] S1    = 2'b01;
  localparam logic [1:0] S2    = 2'b10;
  localparam logic [1:0] S_ILL = 2'b11;

  localparam int HOLD_CNT_W = 4;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_HOLD = 1'b1
  } fsm_t;

  // A wrap is the step that passes through S0 from the far end of the sequence.
  function automatic logic is_wrap(input logic inc, input logic [1:0] cur, input logic [1:0] nxt);
    return (inc && cur == S2 && nxt == S0) || (!inc && cur == S0 && nxt == S2);
  endfunction

endpackage

// File: rtl/cntr3_step_ctrl_if.sv
// rtl/cntr3_step_ctrl_if.sv - request handshake and next-state loop signals of the step controller
interface cntr3_step_ctrl_if;

  logic       req_valid;
  logic       req_inc;
  logic       req_ready;
  logic [1:0] ns_in;
  logic [1:0] state;
  logic       inc_out;
  logic       wrap;
  logic       err;
  logic       busy;

  modport master (
    output req_valid, req_inc, ns_in,
    input  req_ready, state, inc_out, wrap, err, busy
  );

  modport slave (
    input  req_valid, req_inc, ns_in,
    output req_ready, state, inc_out, wrap, err, busy
  );

endinterface

// File: rtl/cntr3_step_ctrl_req_fifo2.sv
// rtl/cntr3_step_ctrl_req_fifo2.sv - two-entry one-bit FIFO holding queued step directions
module req_fifo2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_data,
  input  logic i_pop,
  output logic o_data,
  output logic o_full,
  output logic o_empty
);

  logic [1:0] r_mem;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= 2'b00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cntr3_step_ctrl.sv
// rtl/cntr3_step_ctrl.sv - paced state register and request queue around the cntr3 next-state logic
module cntr3_step_ctrl #(
  parameter int HOLD = 1
) (
  input logic             clk,
  input logic             reset_n,
  cntr3_step_ctrl_if.slave bus
);

  import cntr3_pkg::*;

  localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD = HOLD_CNT_W'((HOLD > 0) ? HOLD - 1 : 0);

  logic [1:0]            r_state;
  logic                  r_wrap;
  logic                  r_err;
  fsm_t                  r_fsm;
  fsm_t                  w_fsm_nxt;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic [HOLD_CNT_W-1:0] w_hold_nxt;
  logic                  w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_update;
  logic                  w_fix_ill;

  req_fifo2 u_req_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (bus.req_valid),
    .i_data  (bus.req_inc),
    .i_pop   (w_update),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_update  = (r_fsm == FSM_IDLE) && !w_empty;
  assign w_fix_ill = (r_fsm == FSM_IDLE) && w_empty && (r_state == S_ILL);

  assign bus.req_ready = !w_full;
  assign bus.inc_out   = w_empty ? 1'b0 : w_head;
  assign bus.state     = r_state;
  assign bus.wrap      = r_wrap;
  assign bus.err       = r_err;
  assign bus.busy      = !w_empty || (r_fsm != FSM_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_update) begin
        if (bus.ns_in == S_ILL) begin
          r_state <= S0;
          r_err   <= 1'b1;
        end else begin
          r_state <= bus.ns_in;
          r_wrap  <= is_wrap(bus.inc_out, r_state, bus.ns_in);
        end
      end else if (w_fix_ill) begin
        r_state <= S0;
        r_err   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm      <= FSM_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // With HOLD = 0 the FSM never leaves IDLE, so updates may occur on every edge.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_hold_nxt = r_hold_cnt;
    case (r_fsm)
      FSM_IDLE: begin
        if (w_update && (HOLD > 0)) begin
          w_fsm_nxt  = FSM_HOLD;
          w_hold_nxt = HOLD_RELOAD;
        end
      end
      FSM_HOLD: begin
        if (r_hold_cnt == '0) begin
          w_fsm_nxt = FSM_IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt - 1'b1;
        end
      end
      default: w_fsm_nxt = FSM_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cntr3_step_ctrl.sv
// tb/tb_cntr3_step_ctrl.sv - table-driven bench for three step controllers with HOLD = 1, 0 and 3
module tb_cntr3_step_ctrl;

  typedef struct {
    int         inst;
    logic       valid;
    logic       inc;
    logic       ill;
    logic [1:0] exp_state;
    logic       exp_wrap;
    logic       exp_err;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v_valid [3];
  logic       v_inc   [3];
  logic       v_ill   [3];
  logic [1:0] o_state [3];
  logic       o_wrap  [3];
  logic       o_err   [3];
  logic       o_ready [3];
  logic       o_busy  [3];
  logic       o_inc   [3];

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  // Reference cntr3 next-state logic closing the loop; 2'b11 maps to 2'b00.
  function automatic logic [1:0] ns_model(input logic [1:0] s, input logic inc);
    case (s)
      2'b00:   return inc ? 2'b01 : 2'b10;
      2'b01:   return inc ? 2'b10 : 2'b00;
      2'b10:   return inc ? 2'b00 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cntr3_step_ctrl_if bus ();
    assign bus.req_valid = v_valid[g];
    assign bus.req_inc   = v_inc[g];
    assign bus.ns_in     = v_ill[g] ? 2'b11 : ns_model(bus.state, bus.inc_out);
    assign o_state[g]    = bus.state;
    assign o_wrap[g]     = bus.wrap;
    assign o_err[g]      = bus.err;
    assign o_ready[g]    = bus.req_ready;
    assign o_busy[g]     = bus.busy;
    assign o_inc[g]      = bus.inc_out;

    cntr3_step_ctrl #(
      .HOLD((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
    );
  end

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  task automatic add(input int inst, input logic valid, input logic inc, input logic ill,
                     input logic [1:0] st, input logic wr, input logic er, input logic rdy, input logic bs);
    vec_t v;
    v.inst = inst; v.valid = valid; v.inc = inc; v.ill = ill;
    v.exp_state = st; v.exp_wrap = wr; v.exp_err = er; v.exp_ready = rdy; v.exp_busy = bs;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      v_valid[k] = 1'b0;
      v_inc[k]   = 1'b0;
      v_ill[k]   = 1'b0;
    end
  endtask

  initial begin
    clear_inputs();

    // reset then idle, HOLD=1 instance
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    // three up steps, HOLD=1
    add(0, 1, 1, 0, 2'b00, 0, 0, 1, 1);
    add(0, 0, 0, 0, 2'b01, 0, 0, 1, 1);
    add(0, 1, 1, 0, 2'b01, 0, 0, 1, 1);
    add(0, 0, 0, 0, 2'b10, 0, 0, 1, 1);
    add(0, 1, 1, 0, 2'b10, 0, 0, 1, 1);
    add(0, 0, 0, 0, 2'b00, 1, 0, 1, 1);
    add(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    add(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    // back-to-back down steps, HOLD=0
    add(1, 1, 0, 0, 2'b00, 0, 0, 1, 1);
    add(1, 1, 0, 0, 2'b10, 1, 0, 1, 1);
    add(1, 1, 0, 0, 2'b01, 0, 0, 1, 1);
    add(1, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    add(1, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    // backpressure, HOLD=3: accepted at edges 1,2,3,7; updates at 2,6,10,14
    add(2, 1, 1, 0, 2'b00, 0, 0, 1, 1);
    add(2, 1, 1, 0, 2'b01, 0, 0, 1, 1);
    add(2, 1, 1, 0, 2'b01, 0, 0, 0, 1);
    add(2, 1, 1, 0, 2'b01, 0, 0, 0, 1);
    add(2, 1, 1, 0, 2'b01, 0, 0, 0, 1);
    add(2, 1, 1, 0, 2'b10, 0, 0, 1, 1);
    add(2, 1, 1, 0, 2'b10, 0, 0, 0, 1);
    add(2, 0, 0, 0, 2'b10, 0, 0, 0, 1);
    add(2, 0, 0, 0, 2'b10, 0, 0, 0, 1);
    add(2, 0, 0, 0, 2'b00, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(2, 0, 0, 0, 2'b00, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(2, 0, 0, 0, 2'b01, 0, 0, 1, 1);
    add(2, 0, 0, 0, 2'b01, 0, 0, 1, 0);
    // illegal next-state injection, HOLD=1; err stays set across later steps
    add(0, 1, 1, 0, 2'b00, 0, 0, 1, 1);
    add(0, 0, 0, 1, 2'b00, 0, 1, 1, 1);
    add(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
    add(0, 1, 1, 0, 2'b00, 0, 1, 1, 1);
    add(0, 0, 0, 0, 2'b01, 0, 1, 1, 1);
    add(0, 0, 0, 0, 2'b01, 0, 1, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_state", k, o_state[k], 2'b00);
      check("rst_ready", k, {1'b0, o_ready[k]}, 2'b01);
      check("rst_inc_out", k, {1'b0, o_inc[k]}, 2'b00);
    end
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      clear_inputs();
      v_valid[vecs[i].inst] = vecs[i].valid;
      v_inc[vecs[i].inst]   = vecs[i].inc;
      v_ill[vecs[i].inst]   = vecs[i].ill;
      @(posedge clk);
      #1;
      check("state", i, o_state[vecs[i].inst], vecs[i].exp_state);
      check("wrap",  i, {1'b0, o_wrap[vecs[i].inst]},  {1'b0, vecs[i].exp_wrap});
      check("err",   i, {1'b0, o_err[vecs[i].inst]},   {1'b0, vecs[i].exp_err});
      check("ready", i, {1'b0, o_ready[vecs[i].inst]}, {1'b0, vecs[i].exp_ready});
      check("busy",  i, {1'b0, o_busy[vecs[i].inst]},  {1'b0, vecs[i].exp_busy});
    end
    clear_inputs();

    // reset clears the sticky error
    reset_n = 1'b0;
    #1;
    check("err_after_reset", 0, {1'b0, o_err[0]}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // reset mid-HOLD with two requests queued, HOLD=3
    v_valid[2] = 1'b1;
    v_inc[2]   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    v_valid[2] = 1'b0;
    check("pre_rst_state", 0, o_state[2], 2'b01);
    check("pre_rst_ready", 0, {1'b0, o_ready[2]}, 2'b00);
    check("pre_rst_inc_out", 0, {1'b0, o_inc[2]}, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 0, o_state[2], 2'b00);
    check("mid_rst_busy",  0, {1'b0, o_busy[2]},  2'b00);
    check("mid_rst_wrap",  0, {1'b0, o_wrap[2]},  2'b00);
    check("mid_rst_ready", 0, {1'b0, o_ready[2]}, 2'b01);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_state", i, o_state[2], 2'b00);
      check("post_rst_busy",  i, {1'b0, o_busy[2]}, 2'b00);
      check("post_rst_wrap",  i, {1'b0, o_wrap[2]}, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
